lfu_access_player: RTL
======================

Name: lfu_access_player

Overview:
- Initiator-side companion to the LFU slot tracker.
- Replays a programmed access string into the tracker's one-hot button inputs. Each access is held long enough for the tracker's internal tick to sample it.
- Reads back the tracker's occupancy LEDs at each press and counts hits and misses.
- Sits between a host/testbench loader and the LFU block; used for FPGA demo and regression.

Parameters:
- NUM_SLOTS, 5, number of tracked slots / button lines
- DEPTH, 16, access-string memory entries
- HOLD_CYCLES, 1024, clk cycles each button is held high (must be at least one tracker tick period)
- GAP_CYCLES, 1024, clk cycles all buttons are low between accesses

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write one access-string entry
- wr_addr  in  $clog2(DEPTH)  entry address
- wr_data  in  3  slot index 0..NUM_SLOTS-1, or 7 = idle (no press)
- len  in  $clog2(DEPTH)+1  number of entries to play, sampled on start
- start  in  1  begin playback (level sampled in IDLE)
- stop  in  1  abort playback
- loop  in  1  restart from entry 0 after the last entry, sampled on start
- led_in  in  NUM_SLOTS  occupancy LEDs from the LFU tracker
- b  out  NUM_SLOTS  one-hot button drive, registered
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at normal completion
- idx  out  $clog2(DEPTH)  entry currently playing
- hit_count  out  16  presses where led_in[slot] was 1 at press start
- miss_count  out  16  presses where led_in[slot] was 0 at press start

Behaviour:
- Reset values: b=0, busy=0, done=0, idx=0, hit_count=0, miss_count=0, state=IDLE, timers=0.
- Memory contents are not reset.
- FSM states: IDLE, FETCH, PRESS, GAP, DONE.
- IDLE:
  - start with len!=0: go to FETCH; idx=0; clear both counters; latch len and loop.
  - start with len==0: done pulses the next cycle; stay IDLE.
  - start is ignored while busy.
- FETCH: one cycle, registered memory read of entry idx, then go to PRESS.
- PRESS: lasts exactly HOLD_CYCLES cycles.
  - b = one-hot(entry) for the whole state.
  - On the first PRESS cycle, increment hit_count if led_in[entry]==1, else increment miss_count.
  - Entry 7, or any entry >= NUM_SLOTS: b stays 0 and neither counter changes.
- GAP: lasts exactly GAP_CYCLES cycles with b=0.
  - Not last entry: idx+1, go to FETCH.
  - Last entry (idx==len-1) with loop: idx=0, go to FETCH.
  - Last entry without loop: go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Access period is 1+HOLD_CYCLES+GAP_CYCLES cycles per entry. b is never high for two different slots in the same cycle.
- stop in any busy state: on the next cycle b=0, state=IDLE, no done pulse, counters hold their values.
- stop and start in the same IDLE cycle: start is ignored.
- wr_en while busy: the write is dropped. wr_en in IDLE writes mem[wr_addr]=wr_data.
- len>DEPTH is clamped to DEPTH on start.
- Counters saturate at 16'hFFFF.
- rst mid-operation: immediate return to reset values on the next edge.

Optional Feature:
- Macro: LFU_PLAYER_HITCNT_EN.
- Defined: hit/miss sampling and counters are implemented as described.
- Undefined: no led_in sampling logic; hit_count and miss_count are tied to 0. The led_in port remains present but unused.

Decomposition:
- Package lfu_pkg holds:
  - NUM_SLOTS default constant
  - slot_idx_t (3-bit)
  - SLOT_IDLE = 3'd7
  - player_state_t enum {IDLE, FETCH, PRESS, GAP, DONE}
  - one-hot helper function
- Sub-module lfu_seq_mem: DEPTH x 3 simple dual-port RAM, synchronous write, one-cycle registered read.

Test Plan:
All cases use HOLD=4, GAP=2, with the start sample at cycle 0.
- Load [0,1,2], len=3, loop=0, start → b=00001 cycles 2-5, 00010 cycles 9-12, 00100 cycles 16-19; done=1 at cycle 22 only; busy low from cycle 23.
- Load [3,7,4], len=3 → b=01000, then 0 for the whole second press window, then 10000; hit_count+miss_count=2.
- led_in=00010 constant, string [0,1], len=2 → miss_count=1, hit_count=1 (with LFU_PLAYER_HITCNT_EN); both 0 without the macro.
- String [0,1], len=2, loop=1, stop asserted at cycle 20 → b=0 from cycle 21, busy=0, done never pulses, idx sequence 0,1,0 observed before stop.
- start with len=0 → done=1 at cycle 1, busy stays 0, b stays 0.
- rst asserted during PRESS of entry 1 → next cycle b=0, busy=0, counters=0; restart replays the previously loaded contents unchanged.

Source files
------------

// File: rtl/lfu_pkg.sv
// -----------------------------------------------------------------------------
// lfu_pkg
// Shared types and helpers for the LFU access player and its sequence memory.
//   DEFAULT_NUM_SLOTS : default number of tracked slots / button lines
//   slot_idx_t        : 3-bit access-string entry (slot index or SLOT_IDLE)
//   SLOT_IDLE         : entry code meaning "no press" for this access
//   player_state_t    : player FSM states
//   slot_onehot()     : entry -> one-hot button vector (zero for idle/out-of-range)
// -----------------------------------------------------------------------------
package lfu_pkg;

    localparam int DEFAULT_NUM_SLOTS = 5;

    typedef logic [2:0] slot_idx_t;

    localparam slot_idx_t SLOT_IDLE = 3'd7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        PRESS = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } player_state_t;

    // Idle code and any index beyond the populated slots map to "no button".
    function automatic logic [7:0] slot_onehot(input slot_idx_t s, input int n);
        logic [7:0] oh;
        oh = 8'd0;
        if ((s != SLOT_IDLE) && (int'(s) < n)) begin
            oh[s] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/lfu_player_if.sv
// -----------------------------------------------------------------------------
// lfu_player_if
// Bundle between the host/loader side, the LFU tracker LEDs and the player.
//   master : host side (drives loader/control and led_in, observes status)
//   slave  : lfu_access_player
// Signals:
//   wr_en/wr_addr/wr_data : access-string write port (accepted only while idle)
//   len/loop/start/stop   : playback control (len/loop sampled on start)
//   led_in                : occupancy LEDs from the tracker
//   b                     : one-hot button drive to the tracker
//   busy/done/idx         : playback status
//   hit_count/miss_count  : press statistics
//   state                 : player FSM state, for debug observation
// Control semantics: start and stop are levels sampled on every clock edge;
// there is no ready back-pressure, start is simply ignored while busy.
// -----------------------------------------------------------------------------
interface lfu_player_if
    import lfu_pkg::*;
#(
    parameter int NUM_SLOTS = DEFAULT_NUM_SLOTS,
    parameter int DEPTH     = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    slot_idx_t            wr_data;
    logic [AW:0]          len;
    logic                 start;
    logic                 stop;
    logic                 loop;
    logic [NUM_SLOTS-1:0] led_in;
    logic [NUM_SLOTS-1:0] b;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        idx;
    logic [15:0]          hit_count;
    logic [15:0]          miss_count;
    player_state_t        state;

    modport master (
        output wr_en, wr_addr, wr_data, len, start, stop, loop, led_in,
        input  b, busy, done, idx, hit_count, miss_count, state
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, len, start, stop, loop, led_in,
        output b, busy, done, idx, hit_count, miss_count, state
    );

endinterface

// File: rtl/lfu_seq_mem.sv
// -----------------------------------------------------------------------------
// lfu_seq_mem
// DEPTH x 3 simple dual-port RAM holding the access string.
//   clk   : clock
//   we    : write enable (synchronous write of wdata to waddr)
//   waddr : write address
//   wdata : entry to store
//   raddr : read address, sampled every edge
//   rdata : registered read data (one-cycle latency)
// Contents are intentionally not reset.
// -----------------------------------------------------------------------------
module lfu_seq_mem
    import lfu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  slot_idx_t     wdata,
    input  logic [AW-1:0] raddr,
    output slot_idx_t     rdata
);

    slot_idx_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/lfu_access_player.sv
// -----------------------------------------------------------------------------
// lfu_access_player
// Replays a programmed access string into the LFU tracker's one-hot button
// inputs: each entry is pressed for HOLD_CYCLES, then all buttons are released
// for GAP_CYCLES. Access period is 1 + HOLD_CYCLES + GAP_CYCLES cycles.
// Ports:
//   clk : clock
//   rst : synchronous, active-high reset
//   bus : lfu_player_if.slave (loader, control, LEDs, buttons, status)
// Configuration macro:
//   LFU_PLAYER_HITCNT_EN : when defined, led_in is sampled on the first cycle
//   of every real press and hit/miss counters (saturating) are kept; when
//   undefined, led_in is unused and both counters read zero.
// -----------------------------------------------------------------------------
module lfu_access_player
    import lfu_pkg::*;
#(
    parameter int NUM_SLOTS   = DEFAULT_NUM_SLOTS,
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 1024,
    parameter int GAP_CYCLES  = 1024
) (
    input logic         clk,
    input logic         rst,
    lfu_player_if.slave bus
);

    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    player_state_t        state_q, state_nxt;
    logic [AW-1:0]        idx_q, idx_nxt;
    logic [TW-1:0]        timer_q, timer_nxt;
    logic [LW-1:0]        len_q, len_nxt;
    logic                 loop_q, loop_nxt;
    logic [NUM_SLOTS-1:0] b_q, b_nxt;
    logic                 busy_q, done_q, done_nxt;
    logic                 clr_cnt;
    logic                 mem_we;
    logic                 last_entry;
    slot_idx_t            rd_data;
    logic [NUM_SLOTS-1:0] press_oh;

    // The read address follows idx_nxt, so the entry is already on rd_data
    // during FETCH and stays there for the whole PRESS (writes are blocked
    // while busy, so the word cannot change underneath).
    lfu_seq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data),
        .raddr (idx_nxt),
        .rdata (rd_data)
    );

    assign mem_we     = bus.wr_en && (state_q == IDLE);
    assign press_oh   = NUM_SLOTS'(slot_onehot(rd_data, NUM_SLOTS));
    assign last_entry = ({1'b0, idx_q} == (len_q - LW'(1)));

    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        timer_nxt = timer_q;
        len_nxt   = len_q;
        loop_nxt  = loop_q;
        done_nxt  = 1'b0;
        clr_cnt   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // stop wins over start when both arrive together.
                if (bus.start && !bus.stop) begin
                    if (bus.len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = FETCH;
                        idx_nxt   = '0;
                        timer_nxt = '0;
                        len_nxt   = (bus.len > LW'(DEPTH)) ? LW'(DEPTH) : bus.len;
                        loop_nxt  = bus.loop;
                        clr_cnt   = 1'b1;
                    end
                end
            end
            FETCH: begin
                state_nxt = PRESS;
                timer_nxt = '0;
            end
            PRESS: begin
                if (timer_q == TW'(HOLD_CYCLES - 1)) begin
                    state_nxt = GAP;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer_q + TW'(1);
                end
            end
            GAP: begin
                if (timer_q == TW'(GAP_CYCLES - 1)) begin
                    timer_nxt = '0;
                    if (!last_entry) begin
                        idx_nxt   = idx_q + AW'(1);
                        state_nxt = FETCH;
                    end else if (loop_q) begin
                        idx_nxt   = '0;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    timer_nxt = timer_q + TW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort: back to IDLE silently, idx and counters keep their values.
        if (bus.stop && (state_q != IDLE)) begin
            state_nxt = IDLE;
            idx_nxt   = idx_q;
            timer_nxt = '0;
        end

        if (state_nxt == DONE) begin
            done_nxt = 1'b1;
        end

        // Buttons are registered off the next state, so they are driven
        // exactly during PRESS cycles and never for two slots at once.
        b_nxt = (state_nxt == PRESS) ? press_oh : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            timer_q <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            idx_q   <= idx_nxt;
            timer_q <= timer_nxt;
            len_q   <= len_nxt;
            loop_q  <= loop_nxt;
            b_q     <= b_nxt;
            busy_q  <= (state_nxt != IDLE);
            done_q  <= done_nxt;
        end
    end

`ifdef LFU_PLAYER_HITCNT_EN
    logic [15:0] hit_q, miss_q;
    logic        sample;
    logic        press_hit;

    // Sample once, on the first PRESS cycle, and only for real presses.
    assign sample    = (state_q == PRESS) && (timer_q == '0) && (press_oh != '0);
    assign press_hit = |(bus.led_in & press_oh);

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (sample) begin
            if (press_hit) begin
                if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
            end else begin
                if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
            end
        end
    end

    assign bus.hit_count  = hit_q;
    assign bus.miss_count = miss_q;
`else
    logic led_unused;
    logic clr_unused;

    assign led_unused     = ^bus.led_in;
    assign clr_unused     = clr_cnt;
    assign bus.hit_count  = 16'd0;
    assign bus.miss_count = 16'd0;
`endif

    assign bus.b     = b_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.idx   = idx_q;
    assign bus.state = state_q;

endmodule
